mac_mmio_driver: RTL and testbench

- Register-mapped initiator that feeds the dual-product MAC accelerator and collects its results.
- The bus side is a simple single-cycle MMIO write/read port.
- The accelerator side drives the operands and input_valid, consumes input_ready, and drives output_ready against output_valid/result.
- Results are queued in a small FIFO so that software can issue back-to-back jobs and drain the results later.

---
 rtl/mac_mmio_pkg.sv | 39 +++
 rtl/mac_result_fifo.sv | 85 ++++++++
 rtl/mac_mmio_driver.sv | 224 ++++++++++++++++++++++
 tb/tb_mac_mmio_driver.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_mmio_pkg.sv
// -----------------------------------------------------------------------------
// mac_mmio_pkg
// Shared constants for the MAC accelerator MMIO driver:
//   - byte addresses of the register map
//   - bit positions inside the CTRL and STATUS registers
//   - FSM state encoding (2 bits)
// No ports; imported by mac_mmio_driver.
// -----------------------------------------------------------------------------
package mac_mmio_pkg;

    // Register map, byte addresses (word aligned).
    localparam int unsigned ADDR_X      = 32'h00;
    localparam int unsigned ADDR_Y      = 32'h04;
    localparam int unsigned ADDR_X2     = 32'h08;
    localparam int unsigned ADDR_Y2     = 32'h0C;
    localparam int unsigned ADDR_PREV   = 32'h10;
    localparam int unsigned ADDR_CTRL   = 32'h14;
    localparam int unsigned ADDR_STATUS = 32'h18;
    localparam int unsigned ADDR_RESULT = 32'h1C;

    // CTRL bits. start and clear are one-shot strobes, ie is stored.
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;
    localparam int CTRL_IE_BIT    = 2;

    // STATUS bits; the FIFO count field starts at ST_COUNT_LSB.
    localparam int ST_BUSY_BIT      = 0;
    localparam int ST_EMPTY_BIT     = 1;
    localparam int ST_FULL_BIT      = 2;
    localparam int ST_START_ERR_BIT = 3;
    localparam int ST_UNDERFLOW_BIT = 4;
    localparam int ST_COUNT_LSB     = 8;

    // Job sequencing states.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

endpackage

// File: rtl/mac_result_fifo.sv
// -----------------------------------------------------------------------------
// mac_result_fifo
// Synchronous result FIFO with a synchronous clear.
//   i_clock, i_reset   clock, asynchronous active-high reset
//   i_push/i_push_data write one entry
//   i_pop              drop the head entry (ignored when empty)
//   i_clear            empty the FIFO; a push in the same cycle survives
//   o_head             current head entry (undefined content when empty)
//   o_count            number of entries, 0..DEPTH
//   o_full, o_empty    occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module mac_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_addr;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Clear dominates a pop; a push on the same cycle lands in the freshly
    // emptied FIFO at slot 0.
    assign w_pop     = i_pop && !o_empty && !i_clear;
    assign w_push    = i_push && (!o_full || w_pop || i_clear);
    assign w_wr_addr = i_clear ? '0 : r_wr_ptr;

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are valid, so clearing the data would buy nothing.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[w_wr_addr] <= i_push_data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample the same pre-edge values.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_push ? PTR_W'(1) : '0;
            r_count  <= w_push ? (PTR_W+1)'(1) : '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mac_mmio_driver.sv
// -----------------------------------------------------------------------------
// mac_mmio_driver
// MMIO-programmed initiator for the dual-product MAC accelerator. Software
// loads operands, writes CTRL.start, and later drains results from a FIFO.
//   i_clock, i_reset                 clock, asynchronous active-high reset
//   i_wr_en/i_wr_addr/i_wr_data      single-cycle MMIO write
//   i_rd_en/i_rd_addr                single-cycle MMIO read request
//   o_rd_data/o_rd_valid             registered read response, 1-cycle latency
//   o_acc_input_valid, i_acc_input_ready, o_acc_x..o_acc_prev   operand side
//   o_acc_output_ready, i_acc_output_valid, i_acc_result       result side
//   o_busy                           a job is in flight
//   o_irq                            result FIFO non-empty and CTRL.ie set
// -----------------------------------------------------------------------------
module mac_mmio_driver
    import mac_mmio_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_acc_input_ready,
    output logic              o_acc_input_valid,
    output logic [WIDTH-1:0]  o_acc_x,
    output logic [WIDTH-1:0]  o_acc_y,
    output logic [WIDTH-1:0]  o_acc_x2,
    output logic [WIDTH-1:0]  o_acc_y2,
    output logic [WIDTH-1:0]  o_acc_prev,
    output logic              o_acc_output_ready,
    input  logic              i_acc_output_valid,
    input  logic [WIDTH-1:0]  i_acc_result,
    output logic              o_busy,
    output logic              o_irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Software-visible operand registers.
    logic [WIDTH-1:0] r_x, r_y, r_x2, r_y2, r_prev;
    // Snapshot of the operands for the job in flight.
    logic [WIDTH-1:0] r_iss_x, r_iss_y, r_iss_x2, r_iss_y2, r_iss_prev;
    logic             r_ie;
    logic             r_start_err;
    logic             r_underflow;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    logic             w_busy;
    logic             w_wr_ctrl;
    logic             w_start;
    logic             w_clear;
    logic             w_start_ok;
    logic             w_start_refused;
    logic             w_rd_result;
    logic             w_pop;
    logic             w_push;
    logic             w_underflow_evt;
    logic [WIDTH-1:0] w_fifo_head;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [WIDTH-1:0] w_status;
    logic [WIDTH-1:0] w_rd_mux;

    function automatic logic hit(input logic [ADDR_W-1:0] a, input int unsigned c);
        return a == ADDR_W'(c);
    endfunction

    // ---------------- control decode ----------------
    assign w_busy          = (r_state != S_IDLE);
    assign w_wr_ctrl       = i_wr_en && hit(i_wr_addr, ADDR_CTRL);
    assign w_start         = w_wr_ctrl && i_wr_data[CTRL_START_BIT];
    assign w_clear         = w_wr_ctrl && i_wr_data[CTRL_CLEAR_BIT];
    // A clear in the same write empties the FIFO first, so it can unblock start.
    assign w_start_ok      = w_start && !w_busy && (!w_fifo_full || w_clear);
    assign w_start_refused = w_start && !w_start_ok;
    assign w_rd_result     = i_rd_en && hit(i_rd_addr, ADDR_RESULT);
    assign w_pop           = w_rd_result && !w_fifo_empty;
    assign w_underflow_evt = w_rd_result && w_fifo_empty;
    // Start is refused when full, so a slot is always free here.
    assign w_push          = (r_state == S_WAIT) && i_acc_output_valid;

    // ---------------- operand and control registers ----------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_x2        <= '0;
            r_y2        <= '0;
            r_prev      <= '0;
            r_ie        <= 1'b0;
            r_start_err <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr_en) begin
                if (hit(i_wr_addr, ADDR_X))         r_x    <= i_wr_data;
                else if (hit(i_wr_addr, ADDR_Y))    r_y    <= i_wr_data;
                else if (hit(i_wr_addr, ADDR_X2))   r_x2   <= i_wr_data;
                else if (hit(i_wr_addr, ADDR_Y2))   r_y2   <= i_wr_data;
                else if (hit(i_wr_addr, ADDR_PREV)) r_prev <= i_wr_data;
            end
            if (w_wr_ctrl) begin
                r_ie <= i_wr_data[CTRL_IE_BIT];
            end
            // Sticky flags: clear applies first, a same-cycle event re-sets.
            r_start_err <= (r_start_err && !w_clear) || w_start_refused;
            r_underflow <= (r_underflow && !w_clear) || w_underflow_evt;
        end
    end

    // ---------------- job FSM ----------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_iss_x    <= '0;
            r_iss_y    <= '0;
            r_iss_x2   <= '0;
            r_iss_y2   <= '0;
            r_iss_prev <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state    <= S_ISSUE;
                        r_iss_x    <= r_x;
                        r_iss_y    <= r_y;
                        r_iss_x2   <= r_x2;
                        r_iss_y2   <= r_y2;
                        r_iss_prev <= r_prev;
                    end
                end
                S_ISSUE: begin
                    if (i_acc_input_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_acc_output_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- result FIFO ----------------
    mac_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data (i_acc_result),
        .i_pop       (w_pop),
        .i_clear     (w_clear),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // ---------------- read path ----------------
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_status                               = '0;
        w_status[ST_BUSY_BIT]                  = w_busy;
        w_status[ST_EMPTY_BIT]                 = w_fifo_empty;
        w_status[ST_FULL_BIT]                  = w_fifo_full;
        w_status[ST_START_ERR_BIT]             = r_start_err;
        w_status[ST_UNDERFLOW_BIT]             = r_underflow;
        w_status[ST_COUNT_LSB +: CNT_W]        = w_fifo_count;
    end

    always_comb begin
        w_rd_mux = '0;
        if (hit(i_rd_addr, ADDR_X))             w_rd_mux = r_x;
        else if (hit(i_rd_addr, ADDR_Y))        w_rd_mux = r_y;
        else if (hit(i_rd_addr, ADDR_X2))       w_rd_mux = r_x2;
        else if (hit(i_rd_addr, ADDR_Y2))       w_rd_mux = r_y2;
        else if (hit(i_rd_addr, ADDR_PREV))     w_rd_mux = r_prev;
        else if (hit(i_rd_addr, ADDR_CTRL))     w_rd_mux[CTRL_IE_BIT] = r_ie;
        else if (hit(i_rd_addr, ADDR_STATUS))   w_rd_mux = w_status;
        else if (hit(i_rd_addr, ADDR_RESULT))   w_rd_mux = w_fifo_empty ? '0 : w_fifo_head;
    end

    // Reads sample pre-edge register values, so a same-cycle write is not seen.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    // ---------------- outputs ----------------
    assign o_rd_data          = r_rd_data;
    assign o_rd_valid         = r_rd_valid;
    assign o_acc_input_valid  = (r_state == S_ISSUE);
    assign o_acc_output_ready = (r_state == S_WAIT);
    assign o_acc_x            = r_iss_x;
    assign o_acc_y            = r_iss_y;
    assign o_acc_x2           = r_iss_x2;
    assign o_acc_y2           = r_iss_y2;
    assign o_acc_prev         = r_iss_prev;
    assign o_busy             = w_busy;
    assign o_irq              = !w_fifo_empty && r_ie;

endmodule

// File: tb/tb_mac_mmio_driver.sv
// -----------------------------------------------------------------------------
// tb_mac_mmio_driver
// Directed bench for mac_mmio_driver (WIDTH=32, ADDR_W=5, DEPTH=4).
// A bench-side accelerator answers the operand/result handshakes with
// result = x*y + x2*y2. A transaction-level model (operand array, result
// queue, job flags) predicts every output each cycle; literal expectations
// pin the model at key points.
// -----------------------------------------------------------------------------
module tb_mac_mmio_driver;

    localparam int DEPTH = 4;

    logic        clock, reset;
    logic        wr_en, rd_en;
    logic [4:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic        rd_valid;
    logic        acc_input_ready, acc_input_valid;
    logic [31:0] acc_x, acc_y, acc_x2, acc_y2, acc_prev;
    logic        acc_output_ready, acc_output_valid;
    logic [31:0] acc_result;
    logic        busy, irq;

    mac_mmio_driver #(.WIDTH(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .i_clock            (clock),
        .i_reset            (reset),
        .i_wr_en            (wr_en),
        .i_wr_addr          (wr_addr),
        .i_wr_data          (wr_data),
        .i_rd_en            (rd_en),
        .i_rd_addr          (rd_addr),
        .o_rd_data          (rd_data),
        .o_rd_valid         (rd_valid),
        .i_acc_input_ready  (acc_input_ready),
        .o_acc_input_valid  (acc_input_valid),
        .o_acc_x            (acc_x),
        .o_acc_y            (acc_y),
        .o_acc_x2           (acc_x2),
        .o_acc_y2           (acc_y2),
        .o_acc_prev         (acc_prev),
        .o_acc_output_ready (acc_output_ready),
        .i_acc_output_valid (acc_output_valid),
        .i_acc_result       (acc_result),
        .o_busy             (busy),
        .o_irq              (irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mac(input logic [31:0] x, y, x2, y2);
        return x * y + x2 * y2;
    endfunction

    // ---------------- bench accelerator ----------------
    bit         out_hold = 1'b0;
    int         out_lat  = 2;
    bit         acc_job, acc_done;
    int         acc_cnt;
    logic [31:0] acc_next;

    initial begin
        acc_output_valid = 1'b0;
        acc_result       = '0;
        acc_job = 0; acc_done = 0; acc_cnt = 0; acc_next = '0;
        forever begin
            @(negedge clock or posedge reset);
            if (reset) begin
                acc_output_valid = 1'b0;
                acc_job = 0; acc_done = 0; acc_cnt = 0;
            end else if (clock == 1'b0) begin
                if (acc_done) begin
                    acc_output_valid = 1'b0;
                    acc_job = 0; acc_done = 0;
                end
                if (!acc_job && acc_input_valid && acc_input_ready) begin
                    acc_job  = 1;
                    acc_cnt  = out_lat;
                    acc_next = mac(acc_x, acc_y, acc_x2, acc_y2);
                end else if (acc_job && !acc_output_valid) begin
                    if (acc_cnt > 0) acc_cnt--;
                    else if (!out_hold) begin
                        acc_output_valid = 1'b1;
                        acc_result       = acc_next;
                    end
                end
                if (acc_output_valid && acc_output_ready) acc_done = 1;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    logic [31:0] m_reg [5];
    logic [31:0] m_job [5];
    logic [31:0] m_q [$];
    bit          m_busy, m_issued, m_ie, m_err, m_unf, m_rd_valid;
    logic [31:0] m_rd_data;

    function automatic logic [31:0] status_word();
        logic [31:0] s;
        s = '0;
        s[0] = m_busy;
        s[1] = (m_q.size() == 0);
        s[2] = (m_q.size() == DEPTH);
        s[3] = m_err;
        s[4] = m_unf;
        s[15:8] = 8'(m_q.size());
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin m_reg[i] = '0; m_job[i] = '0; end
        m_q.delete();
        m_busy = 0; m_issued = 0; m_ie = 0; m_err = 0; m_unf = 0;
        m_rd_valid = 0; m_rd_data = '0;
    endtask

    task automatic model_step();
        bit wctrl, clr, start, ok, pop, push, unf_evt;
        wctrl   = wr_en && (wr_addr == 5'h14);
        clr     = wctrl && wr_data[1];
        start   = wctrl && wr_data[0];
        pop     = 0;
        unf_evt = 0;
        m_rd_valid = rd_en;
        if (rd_en) begin
            case (rd_addr)
                5'h00: m_rd_data = m_reg[0];
                5'h04: m_rd_data = m_reg[1];
                5'h08: m_rd_data = m_reg[2];
                5'h0C: m_rd_data = m_reg[3];
                5'h10: m_rd_data = m_reg[4];
                5'h14: m_rd_data = {29'd0, m_ie, 2'b00};
                5'h18: m_rd_data = status_word();
                5'h1C: begin
                    if (m_q.size() != 0) begin m_rd_data = m_q[0]; pop = 1; end
                    else begin m_rd_data = '0; unf_evt = 1; end
                end
                default: m_rd_data = '0;
            endcase
        end
        push = m_busy && m_issued && acc_output_valid;
        ok   = start && !m_busy && (clr || m_q.size() < DEPTH);
        if (clr) m_q.delete();
        else if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(mac(m_job[0], m_job[1], m_job[2], m_job[3]));
            m_busy = 0;
        end else if (m_busy && !m_issued && acc_input_ready) begin
            m_issued = 1;
        end
        m_unf = (m_unf && !clr) || unf_evt;
        m_err = (m_err && !clr) || (start && !ok);
        if (wctrl) m_ie = wr_data[2];
        if (ok) begin m_busy = 1; m_issued = 0; m_job = m_reg; end
        if (wr_en && wr_addr[1:0] == 2'b00 && wr_addr < 5'h14) m_reg[wr_addr[4:2]] = wr_data;
    endtask

    task automatic compare();
        check("busy", busy, m_busy);
        check("acc_input_valid", acc_input_valid, m_busy && !m_issued);
        check("acc_output_ready", acc_output_ready, m_busy && m_issued);
        check("irq", irq, m_ie && m_q.size() != 0);
        if (m_busy) begin
            check("acc_x", acc_x, m_job[0]);
            check("acc_y", acc_y, m_job[1]);
            check("acc_x2", acc_x2, m_job[2]);
            check("acc_y2", acc_y2, m_job[3]);
            check("acc_prev", acc_prev, m_job[4]);
        end
        check("rd_valid", rd_valid, m_rd_valid);
        if (m_rd_valid) check("rd_data", rd_data, m_rd_data);
    endtask

    always @(posedge clock) begin
        if (reset) model_reset();
        else model_step();
        #1;
        if (chk_en && !reset) compare();
    end

    // ---------------- stimulus helpers (entered at posedge+2) ----------------
    task automatic mmio_write(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clock); #2;
        wr_en = 1'b0;
    endtask

    task automatic mmio_read(input logic [4:0] a, output logic [31:0] d);
        rd_en = 1'b1; rd_addr = a;
        @(posedge clock); #2;
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clock); #2; end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin @(posedge clock); #2; n++; end
        check("job_done_in_budget", busy, 1'b0);
    endtask

    task automatic run_job(input logic [31:0] x, input logic [31:0] ctrl);
        mmio_write(5'h00, x);
        mmio_write(5'h14, ctrl);
        wait_idle();
    endtask

    logic [31:0] d;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 0; rd_en = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        acc_input_ready = 1'b1;
        @(posedge clock); @(posedge clock); #2;
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_irq", irq, 0);
        check("reset_in_valid", acc_input_valid, 0);
        check("reset_out_ready", acc_output_ready, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        chk_en = 1'b1;

        // Basic job: 3*4 + 5*6 = 42 = 0x2A.
        mmio_write(5'h04, 32'd4);
        mmio_write(5'h08, 32'd5);
        mmio_write(5'h0C, 32'd6);
        mmio_write(5'h10, 32'h11);
        mmio_write(5'h00, 32'd3);
        mmio_write(5'h14, 32'h1);
        check("basic_busy", busy, 1);
        check("basic_in_valid", acc_input_valid, 1);
        check("basic_acc_x", acc_x, 3);
        check("basic_acc_y2", acc_y2, 6);
        wait_idle();
        mmio_read(5'h18, d); check("basic_status_count1", d, 32'h100);
        mmio_read(5'h1C, d); check("basic_result", d, 32'h2A);
        mmio_read(5'h18, d); check("basic_status_empty", d, 32'h2);

        // Same-cycle write/read of X returns the old value; unaligned read is 0.
        wr_en = 1; wr_addr = 5'h00; wr_data = 32'h55; rd_en = 1; rd_addr = 5'h00;
        @(posedge clock); #2; wr_en = 0; rd_en = 0;
        check("x_read_old", rd_data, 32'd3);
        mmio_read(5'h00, d); check("x_read_new", d, 32'h55);
        mmio_read(5'h02, d); check("unmapped_read", d, 32'h0);

        // Backpressure: operands frozen while input_ready is low.
        acc_input_ready = 1'b0;
        mmio_write(5'h00, 32'd3);
        mmio_write(5'h14, 32'h1);
        cycles(3);
        mmio_write(5'h00, 32'd9);
        cycles(6);
        check("bp_in_valid_held", acc_input_valid, 1);
        check("bp_acc_x_stable", acc_x, 3);
        acc_input_ready = 1'b1;
        wait_idle();
        mmio_read(5'h1C, d); check("bp_result", d, 32'h2A);

        // FIFO full: results 4x+30 for x=1..4 are 34,38,42,46.
        for (int i = 1; i <= 4; i++) run_job(i, 32'h1);
        mmio_read(5'h18, d); check("full_status", d, 32'h404);
        mmio_write(5'h14, 32'h1);
        check("full_start_ignored", busy, 0);
        mmio_read(5'h18, d); check("full_start_err", d, 32'h40C);
        for (int i = 1; i <= 4; i++) begin
            mmio_read(5'h1C, d); check("full_drain", d, 4 * i + 30);
        end
        for (int i = 5; i <= 8; i++) run_job(i, 32'h1);
        for (int i = 5; i <= 8; i++) begin
            mmio_read(5'h1C, d); check("wrap_drain", d, 4 * i + 30);
        end

        // Underflow and clear.
        mmio_read(5'h1C, d); check("underflow_data", d, 32'h0);
        mmio_read(5'h18, d); check("underflow_status", d, 32'h1A);
        mmio_write(5'h14, 32'h2);
        mmio_read(5'h18, d); check("clear_status", d, 32'h2);
        mmio_write(5'h14, 32'h4);
        mmio_read(5'h14, d); check("ctrl_ie_read", d, 32'h4);
        run_job(1, 32'h5);
        check("irq_level", irq, 1);
        out_hold = 1'b1;
        mmio_write(5'h00, 32'd2);
        mmio_write(5'h14, 32'h5);
        cycles(5);
        check("hold_in_wait", acc_output_ready, 1);
        mmio_write(5'h14, 32'h6);
        out_hold = 1'b0;
        wait_idle();
        mmio_read(5'h18, d); check("clear_wait_count1", d, 32'h100);
        mmio_read(5'h1C, d); check("clear_wait_result", d, 32'd38);

        // Simultaneous push and pop with two entries queued.
        run_job(1, 32'h5);
        run_job(2, 32'h5);
        out_hold = 1'b1;
        mmio_write(5'h00, 32'd3);
        mmio_write(5'h14, 32'h5);
        cycles(5);
        out_hold = 1'b0; rd_en = 1'b1; rd_addr = 5'h1C;
        @(posedge clock); #2; rd_en = 1'b0;
        check("pushpop_oldest", rd_data, 32'd34);
        wait_idle();
        mmio_read(5'h18, d); check("pushpop_count2", d, 32'h200);

        // Asynchronous reset while a job waits for its result.
        out_hold = 1'b1;
        mmio_write(5'h00, 32'd4);
        mmio_write(5'h14, 32'h5);
        cycles(4);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_irq", irq, 1);
        #1 reset = 1'b1;
        #1;
        check("arst_in_valid", acc_input_valid, 0);
        check("arst_out_ready", acc_output_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_irq", irq, 0);
        @(posedge clock); #2;
        reset = 1'b0; out_hold = 1'b0;
        mmio_read(5'h18, d); check("post_reset_status", d, 32'h2);
        mmio_write(5'h04, 32'd8);
        mmio_write(5'h08, 32'd2);
        mmio_write(5'h0C, 32'd3);
        mmio_write(5'h10, 32'h99);
        run_job(7, 32'h1);
        mmio_read(5'h1C, d); check("post_reset_result", d, 32'd62);
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
